// File: rtl/sext_shifter_pkg.sv
// Shared widths and the sign-extension helper used by the immediate formatting paths.
package sext_shifter_pkg;

  localparam int ADDR_W     = 16;
  localparam int IMM_W      = 12;
  localparam int BR_W       = 8;
  localparam int WORD_SHIFT = 1;
  localparam int SEXT_MAX_W = 64;

  // Sign-extends the low from_width bits of value; bits above from_width are ignored.
  function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] value,
                                                input int from_width);
    logic [SEXT_MAX_W-1:0] upper;
    logic                  sign;
    upper = {SEXT_MAX_W{1'b1}} << from_width;
    sign  = |(value & (SEXT_MAX_W'(1) << (from_width - 1)));
    return sign ? (value | upper) : (value & ~upper);
  endfunction

endpackage

// File: rtl/sext_shifter_if.sv
// Offset request/result bundle between the immediate decoder (master) and the formatter (slave).
interface sext_shifter_if
  import sext_shifter_pkg::*;
#(
  parameter int IN_WIDTH  = IMM_W,
  parameter int OUT_WIDTH = ADDR_W
);
  logic                 in_valid;
  logic [IN_WIDTH-1:0]  data_in;
  logic                 jump;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] data_out;

  modport master (output in_valid, data_in, jump, input out_valid, data_out);
  modport slave  (input in_valid, data_in, jump, output out_valid, data_out);
endinterface

// File: rtl/sext_shift_core.sv
// Purpose: pick branch/jump offset field, sign-extend to address width, scale by left shift.
// Latency: combinational.
// Backpressure: none.
module sext_shift_core
  import sext_shifter_pkg::*;
#(
  parameter int IN_WIDTH  = IMM_W,
  parameter int BR_WIDTH  = BR_W,
  parameter int OUT_WIDTH = ADDR_W,
  parameter int SHIFT     = WORD_SHIFT
) (
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic                 jump,
  output logic [OUT_WIDTH-1:0] result
);

  logic [OUT_WIDTH-1:0] ext;

  // The branch path hands sext the whole field; sext ignores bits above BR_WIDTH.
  always_comb begin
    ext = '0;
    if (jump) begin
      ext = OUT_WIDTH'(sext(SEXT_MAX_W'(data_in), IN_WIDTH));
    end else begin
      ext = OUT_WIDTH'(sext(SEXT_MAX_W'(data_in), BR_WIDTH));
    end
    result = ext << SHIFT;
  end

endmodule

// File: rtl/sext_shifter.sv
// Purpose: registered branch/jump offset formatter for the PC datapath.
// Latency: 1 cycle, one result per cycle.
// Backpressure: none; every in_valid produces out_valid on the next cycle.
module sext_shifter
  import sext_shifter_pkg::*;
#(
  parameter int IN_WIDTH  = IMM_W,
  parameter int BR_WIDTH  = BR_W,
  parameter int OUT_WIDTH = ADDR_W,
  parameter int SHIFT     = WORD_SHIFT
) (
  input logic           clk,
  input logic           reset,
  sext_shifter_if.slave bus
);

  if (BR_WIDTH < 1 || BR_WIDTH > IN_WIDTH || SHIFT < 0 ||
      IN_WIDTH + SHIFT > OUT_WIDTH || OUT_WIDTH > SEXT_MAX_W) begin : g_bad_params
    $error("sext_shifter: illegal parameters IN=%0d BR=%0d OUT=%0d SHIFT=%0d",
           IN_WIDTH, BR_WIDTH, OUT_WIDTH, SHIFT);
  end

  logic [OUT_WIDTH-1:0] result;

  sext_shift_core #(
    .IN_WIDTH (IN_WIDTH),
    .BR_WIDTH (BR_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT)
  ) u_core (
    .data_in(bus.data_in),
    .jump   (bus.jump),
    .result (result)
  );

  // data_out only loads under in_valid, so idle-cycle garbage never reaches it.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.data_out  <= '0;
      bus.out_valid <= 1'b0;
    end else if (bus.in_valid) begin
      bus.data_out  <= result;
      bus.out_valid <= 1'b1;
    end else begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sext_shifter.sv
// Bench for sext_shifter: default and alternate parameter sets checked against an arithmetic model.
module tb_sext_shifter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  sext_shifter_if #(.IN_WIDTH(12), .OUT_WIDTH(16)) bus_a ();
  sext_shifter_if #(.IN_WIDTH(10), .OUT_WIDTH(12)) bus_b ();

  sext_shifter #(.IN_WIDTH(12), .BR_WIDTH(8), .OUT_WIDTH(16), .SHIFT(1)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a.slave)
  );

  sext_shifter #(.IN_WIDTH(10), .BR_WIDTH(6), .OUT_WIDTH(12), .SHIFT(2)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offset as a signed integer, scaled by 2**sh, reduced modulo 2**outw.
  function automatic longint ref_off(longint d, bit j, int inw, int brw, int outw, int sh);
    int     w;
    longint f;
    longint m;
    w = j ? inw : brw;
    f = d % (longint'(1) << w);
    if (f >= (longint'(1) << (w - 1))) f = f - (longint'(1) << w);
    f = f * (longint'(1) << sh);
    m = f % (longint'(1) << outw);
    if (m < 0) m = m + (longint'(1) << outw);
    return m;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic        ma_vld, mb_vld;
  logic [15:0] ma_dat;
  logic [11:0] mb_dat;

  // Drives both DUTs for one cycle, advances the model, then compares both outputs.
  task automatic step(input bit rst, input bit v, input bit j, input logic [11:0] d);
    logic [9:0] d_b;
    d_b            = d[9:0];
    reset          = rst;
    bus_a.in_valid = v;
    bus_a.jump     = j;
    bus_a.data_in  = d;
    bus_b.in_valid = v;
    bus_b.jump     = j;
    bus_b.data_in  = d_b;
    @(posedge clk);
    #1;
    if (rst) begin
      ma_vld = 1'b0; ma_dat = '0;
      mb_vld = 1'b0; mb_dat = '0;
    end else if (v) begin
      ma_vld = 1'b1; ma_dat = 16'(ref_off(longint'(d), j, 12, 8, 16, 1));
      mb_vld = 1'b1; mb_dat = 12'(ref_off(longint'(d_b), j, 10, 6, 12, 2));
    end else begin
      ma_vld = 1'b0;
      mb_vld = 1'b0;
    end
    check("a_out_valid", 16'(bus_a.out_valid), 16'(ma_vld));
    check("a_data_out",  bus_a.data_out, ma_dat);
    check("b_out_valid", 16'(bus_b.out_valid), 16'(mb_vld));
    check("b_data_out",  16'(bus_b.data_out), 16'(mb_dat));
  endtask

  logic [11:0] vec_d [11];
  bit          vec_j [11];
  logic [15:0] vec_e [11];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    vec_d = '{12'h000, 12'h001, 12'h081, 12'h800, 12'h801, 12'h881,
              12'h001, 12'h081, 12'h800, 12'h801, 12'h881};
    vec_j = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    vec_e = '{16'h0000, 16'h0002, 16'hFF02, 16'h0000, 16'h0002, 16'hFF02,
              16'h0002, 16'h0102, 16'hF000, 16'hF002, 16'hF102};

    reset = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.jump = 1'b0; bus_a.data_in = '0;
    bus_b.in_valid = 1'b0; bus_b.jump = 1'b0; bus_b.data_in = '0;

    // Reset wins over a simultaneous valid input.
    step(1'b1, 1'b1, 1'b1, 12'h881);
    check("reset_valid", 16'(bus_a.out_valid), 16'h0000);
    check("reset_data",  bus_a.data_out, 16'h0000);

    for (int i = 0; i < 11; i++) begin
      step(1'b0, 1'b1, vec_j[i], vec_d[i]);
      check($sformatf("vec%0d_j%0d_%h", i, vec_j[i], vec_d[i]), bus_a.data_out, vec_e[i]);
    end

    // Idle cycle with unknown data: valid drops, data holds.
    step(1'b0, 1'b0, 1'b1, 12'hxxx);
    check("drop_hold", bus_a.data_out, 16'hF102);

    step(1'b0, 1'b1, 1'b0, 12'h020);
    check("alt_params_020", 16'(bus_b.data_out), 16'h0F80);

    // Back-to-back, alternating jump.
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b1, 1'(i % 2), 12'($urandom));
    end

    // Random mix of idle cycles (unknown data), valid inputs and an occasional reset.
    for (int i = 0; i < 60; i++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      if (v) step(($urandom_range(0, 19) == 0), 1'b1, 1'($urandom), 12'($urandom));
      else   step(1'b0, 1'b0, 1'($urandom), 12'hxxx);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
